// File: rtl/pmbist_march_engine.sv
// pmbist_march_engine
//   Responder end of the BIST instruction interface. A rising edge on ts
//   latches the scan instruction word and runs one march element over the
//   memory under test through a single-port synchronous SRAM port. Read data
//   is compared with the expected pattern, and the block reports a sticky
//   pass/fail result.
//
//   Instruction word (scan):
//     [23]    UPDWN  0 = ascending, 1 = descending
//     [22:19] OP3..OP0   1 = write, 0 = read
//     [18:15] POL3..POL0 1 = invert pattern for that op
//     [14:13] NO     op count minus 1
//     [12:5]  DATA   base pattern
//     [4]     W      checkerboard (pattern ^= {8{addr[0]}})
//     [3:0]   ADMD   range 0..2^ADMD-1 (full range when ADMD >= ADDR_W)
//
//   Ports:
//     clk, rst            clock (rising edge), async active-low reset
//     scan, ts            instruction word, test-start strobe
//     mem_en, mem_we      access strobe, 1 = write / 0 = read
//     mem_addr, mem_wdata access address, write data
//     mem_rdata           read data, valid one cycle after a read strobe
//     busy, done          run in progress, run complete (held)
//     passfail            1 = pass, meaningful while done = 1
//     fail_addr/fail_data first failing address and its read data
//     dbg_state           current FSM state, for observation only
//
//   Optional feature: define PMBIST_FAIL_LOG_EN to capture the first failing
//   read into fail_addr/fail_data; otherwise both outputs are tied to 0.
//
//   Handshake: there is no valid/ready pair here. A run is requested by a
//   0->1 transition on ts while idle or done; busy is high for the whole run
//   and done rises on the same edge busy falls, then holds until the next
//   accepted start or reset.
module pmbist_march_engine #(
  parameter int SCAN_WIDTH = 24,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SCAN_WIDTH-1:0] scan,
  input  logic                  ts,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  passfail,
  output logic [ADDR_W-1:0]     fail_addr,
  output logic [DATA_W-1:0]     fail_data,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_OP     = 3'd1,
    S_RD_CMP = 3'd2,
    S_NEXT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                state;
  logic [SCAN_WIDTH-1:0] ir;
  logic [1:0]            k;
  logic [ADDR_W-1:0]     addr;
  logic                  fail;
  logic                  ts_q;

  logic                  start;
  logic                  at_end;
  logic                  rd_mismatch;
  logic [ADDR_W-1:0]     start_addr;
  logic [ADDR_W-1:0]     step_addr;
  logic [1:0]            k_inc;

  // Op k is a write when its OP bit is set.
  function automatic logic op_wr(input logic [SCAN_WIDTH-1:0] w,
                                 input logic [1:0] idx);
    logic [3:0] ops;
    ops = w[22:19];
    return ops[idx];
  endfunction

  // Write / expected data for op idx at address a.
  function automatic logic [DATA_W-1:0] op_data(input logic [SCAN_WIDTH-1:0] w,
                                                input logic [ADDR_W-1:0] a,
                                                input logic [1:0] idx);
    logic [DATA_W-1:0] p;
    logic [3:0]        pol;
    p   = w[12:5];
    pol = w[18:15];
    if (w[4])     p = p ^ {DATA_W{a[0]}};
    if (pol[idx]) p = ~p;
    return p;
  endfunction

  // Highest address of the tested range.
  function automatic logic [ADDR_W-1:0] last_addr(input logic [SCAN_WIDTH-1:0] w);
    logic [3:0] admd;
    admd = w[3:0];
    if (32'(admd) >= ADDR_W) return '1;
    return ~({ADDR_W{1'b1}} << admd);
  endfunction

  assign start       = ts & ~ts_q;
  assign start_addr  = scan[23] ? last_addr(scan) : '0;
  assign step_addr   = ir[23] ? addr - 1'b1 : addr + 1'b1;
  assign k_inc       = k + 2'd1;
  // Explicit end compare: the counter never wraps past either end.
  assign at_end      = ir[23] ? (addr == '0) : (addr == last_addr(ir));
  assign rd_mismatch = (mem_rdata != op_data(ir, addr, k));

  assign mem_addr  = addr;
  assign dbg_state = state;

  // Memory strobes are registered together with the transition into S_OP,
  // so mem_en is high exactly in S_OP cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      ir        <= '0;
      k         <= '0;
      addr      <= '0;
      fail      <= 1'b0;
      ts_q      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      passfail  <= 1'b0;
    end else begin
      ts_q   <= ts;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            ir        <= scan;
            busy      <= 1'b1;
            done      <= 1'b0;
            passfail  <= 1'b0;
            fail      <= 1'b0;
            k         <= 2'd0;
            addr      <= start_addr;
            mem_en    <= 1'b1;
            mem_we    <= op_wr(scan, 2'd0);
            mem_wdata <= op_data(scan, start_addr, 2'd0);
            state     <= S_OP;
          end
        end
        S_OP: begin
          if (!op_wr(ir, k)) begin
            state <= S_RD_CMP;
          end else if (k == ir[14:13]) begin
            state <= S_NEXT;
          end else begin
            k         <= k_inc;
            mem_en    <= 1'b1;
            mem_we    <= op_wr(ir, k_inc);
            mem_wdata <= op_data(ir, addr, k_inc);
            state     <= S_OP;
          end
        end
        S_RD_CMP: begin
          if (rd_mismatch) fail <= 1'b1;
          if (k == ir[14:13]) begin
            state <= S_NEXT;
          end else begin
            k         <= k_inc;
            mem_en    <= 1'b1;
            mem_we    <= op_wr(ir, k_inc);
            mem_wdata <= op_data(ir, addr, k_inc);
            state     <= S_OP;
          end
        end
        S_NEXT: begin
          k <= 2'd0;
          if (at_end) begin
            busy     <= 1'b0;
            done     <= 1'b1;
            passfail <= ~fail;
            state    <= S_DONE;
          end else begin
            addr      <= step_addr;
            mem_en    <= 1'b1;
            mem_we    <= op_wr(ir, 2'd0);
            mem_wdata <= op_data(ir, step_addr, 2'd0);
            state     <= S_OP;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PMBIST_FAIL_LOG_EN
  // Only the first mismatch of a run is logged; cleared on an accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fail_addr <= '0;
      fail_data <= '0;
    end else if (start && (state == S_IDLE || state == S_DONE)) begin
      fail_addr <= '0;
      fail_data <= '0;
    end else if (state == S_RD_CMP && rd_mismatch && !fail) begin
      fail_addr <= addr;
      fail_data <= mem_rdata;
    end
  end
`else
  assign fail_addr = '0;
  assign fail_data = '0;
`endif

endmodule
